// File: rtl/iiit_fifo_gen.sv
// Synchronous FIFO with fill/threshold flags, sticky error flags, flush, and
// optional first-word-fall-through output.
module iiit_fifo_gen #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 3,
    parameter int AF_THRESH = (1 << ADDR_W) - 1,
    parameter int AE_THRESH = 1,
    parameter bit FWFT      = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] buf_in,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic              flush,
    output logic [DATA_W-1:0] buf_out,
    output logic              buf_empty,
    output logic              buf_full,
    output logic              almost_empty,
    output logic              almost_full,
    output logic              overflow,
    output logic              underflow,
    output logic [ADDR_W:0]   fifo_counter
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              wr_acc, rd_acc;

    assign buf_empty    = (cnt_q == '0);
    assign buf_full     = (cnt_q == (ADDR_W+1)'(DEPTH));
    assign almost_full  = (cnt_q >= (ADDR_W+1)'(AF_THRESH));
    assign almost_empty = (cnt_q <= (ADDR_W+1)'(AE_THRESH));
    assign fifo_counter = cnt_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

    // Flags are pre-edge state, so a full FIFO takes only the read and an
    // empty FIFO takes only the write; flush suppresses both.
    assign wr_acc = wr_en && !buf_full && !flush;
    assign rd_acc = rd_en && !buf_empty && !flush;

    // FWFT shows the head word directly; empty shows zeros so no stale data leaks.
    assign buf_out = FWFT ? (buf_empty ? '0 : mem[rd_ptr_q]) : dout_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        dout_d   = dout_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
            ovf_d    = 1'b0;
            unf_d    = 1'b0;
        end else begin
            if (wr_en && buf_full)  ovf_d = 1'b1;
            if (rd_en && buf_empty) unf_d = 1'b1;
            if (wr_acc) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
            if (rd_acc) begin
                rd_ptr_d = rd_ptr_q + ADDR_W'(1);
                dout_d   = mem[rd_ptr_q];
            end
            case ({wr_acc, rd_acc})
                2'b10:   cnt_d = cnt_q + (ADDR_W+1)'(1);
                2'b01:   cnt_d = cnt_q - (ADDR_W+1)'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            dout_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            dout_q   <= dout_d;
        end
    end

    // Storage is not reset; reset only invalidates it through the pointers.
    always_ff @(posedge clk) begin
        if (wr_acc) mem[wr_ptr_q] <= buf_in;
    end

endmodule

// File: tb/tb_iiit_fifo_gen.sv
// Scoreboard bench: a registered-read and an FWFT instance share stimulus and
// are checked against a queue-based model of the FIFO.
module tb_iiit_fifo_gen;
    localparam int DEPTH = 8;
    localparam int AF    = 6;
    localparam int AE    = 1;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wr_en = 1'b0, rd_en = 1'b0, flush = 1'b0;
    logic [7:0] buf_in = 8'h00;
    logic [7:0] out0, out1;
    logic       e0, f0, ae0, af0, ov0, un0;
    logic       e1, f1, ae1, af1, ov1, un1;
    logic [3:0] cnt0, cnt1;

    int         n_chk = 0;
    int         n_pass = 0;
    logic [7:0] mq[$];
    logic [7:0] exp_q[$];
    logic       m_ovf = 1'b0, m_unf = 1'b0;
    logic [7:0] last_out = 8'h00;
    logic       rd_hs = 1'b0;

    always #5 clk = ~clk;

    iiit_fifo_gen #(.DATA_W(8), .ADDR_W(3), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(1'b0)) dut0 (
        .clk(clk), .rst(rst), .buf_in(buf_in), .wr_en(wr_en), .rd_en(rd_en), .flush(flush),
        .buf_out(out0), .buf_empty(e0), .buf_full(f0), .almost_empty(ae0), .almost_full(af0),
        .overflow(ov0), .underflow(un0), .fifo_counter(cnt0));

    iiit_fifo_gen #(.DATA_W(8), .ADDR_W(3), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(1'b1)) dut1 (
        .clk(clk), .rst(rst), .buf_in(buf_in), .wr_en(wr_en), .rd_en(rd_en), .flush(flush),
        .buf_out(out1), .buf_empty(e1), .buf_full(f1), .almost_empty(ae1), .almost_full(af1),
        .overflow(ov1), .underflow(un1), .fifo_counter(cnt1));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    function automatic logic [9:0] mstat();
        int c;
        c = mq.size();
        return {4'(c), c == 0, c == DEPTH, c <= AE, c >= AF, m_ovf, m_unf};
    endfunction

    task automatic check_all();
        logic [7:0] head;
        head = (mq.size() > 0) ? mq[0] : 8'h00;
        chk("status_reg",  {22'd0, cnt0, e0, f0, ae0, af0, ov0, un0}, {22'd0, mstat()});
        chk("status_fwft", {22'd0, cnt1, e1, f1, ae1, af1, ov1, un1}, {22'd0, mstat()});
        chk("out_reg_hold", {24'd0, out0}, {24'd0, last_out});
        chk("out_fwft",     {24'd0, out1}, {24'd0, head});
    endtask

    // One clock of stimulus; the model decides acceptance from pre-edge occupancy.
    task automatic step(input logic w, input logic r, input logic f, input logic [7:0] d);
        bit full, empty;
        @(negedge clk);
        wr_en = w; rd_en = r; flush = f; buf_in = d;
        if (f) begin
            mq.delete(); m_ovf = 1'b0; m_unf = 1'b0;
        end else begin
            full  = (mq.size() == DEPTH);
            empty = (mq.size() == 0);
            if (w && full)  m_ovf = 1'b1;
            if (r && empty) m_unf = 1'b1;
            if (r && !empty) begin
                last_out = mq.pop_front();
                exp_q.push_back(last_out);
            end
            if (w && !full) mq.push_back(d);
        end
        #3 rd_hs = rd_en && !e0 && !flush && rst;
        @(posedge clk);
        #2 check_all();
    endtask

    task automatic mid_reset();
        @(negedge clk);
        wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; rd_hs = 1'b0;
        #2 rst = 1'b0;
        mq.delete(); m_ovf = 1'b0; m_unf = 1'b0; last_out = 8'h00;
        #1 check_all();
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Monitor: the registered instance presents a word one cycle after a handshake.
    initial forever begin
        @(posedge clk);
        if (rd_hs) begin
            #1;
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL pop_data: unexpected pop, got %0h expected none", out0);
            end else begin
                chk("pop_data", {24'd0, out0}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent, guard, c;
        logic w, r;
        #1 check_all();
        @(negedge clk);
        rst = 1'b1;

        // Fill to full, then one push too many.
        for (int i = 1; i <= 8; i++) step(1'b1, 1'b0, 1'b0, 8'(i));
        step(1'b1, 1'b0, 1'b0, 8'h09);
        // Drain in order, then one pop too many (output holds 0x08).
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b1, 1'b0, 8'h00);

        // Flush with 4 words stored and a concurrent write.
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 8'h20 + 8'(i));
        step(1'b1, 1'b0, 1'b1, 8'hEE);

        // Stream 20 words with occupancy kept within 2..5.
        sent = 0; guard = 0;
        while ((sent < 20 || mq.size() > 0) && guard < 400) begin
            c = mq.size();
            w = (sent < 20) && (c < 5) && (c < 2 || $urandom_range(0, 1) == 1);
            r = (c > 0) && (sent == 20 || (c > 2 && $urandom_range(0, 1) == 1));
            step(w, r, 1'b0, 8'($urandom_range(0, 255)));
            if (w) sent++;
            guard++;
        end
        chk("wrap_done", guard < 400, 1'b1);

        // Simultaneous access at full and at empty.
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, 8'h80 + 8'(i));
        step(1'b1, 1'b1, 1'b0, 8'hFF);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b1, 1'b0, 8'h5A);
        step(1'b0, 1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b1, 8'h00);

        // FWFT: head visible without a read; empty after the pop.
        step(1'b1, 1'b0, 1'b0, 8'hA5);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 1'b0, 8'h00);

        // Random traffic with occasional flush.
        for (int i = 0; i < 300; i++)
            step($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 31) == 0, 8'($urandom_range(0, 255)));

        // Asynchronous reset in the middle of a clock period with data stored.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 8'h30 + 8'(i));
        mid_reset();
        step(1'b1, 1'b1, 1'b0, 8'h77);
        step(1'b0, 1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b0, 8'h00);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/iiit_fifo_gen.md
IIIT_FIFO_GEN -- requirements
Module: iiit_fifo_gen

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning data word width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 3, meaning pointer width; DEPTH = 2**ADDR_W entries.
REQ-003 The block SHALL have parameter AF_THRESH, default DEPTH-1, meaning the almost_full assert level, range 1..DEPTH.
REQ-004 The block SHALL have parameter AE_THRESH, default 1, meaning the almost_empty assert level, range 0..DEPTH-1.
REQ-005 The block SHALL have parameter FWFT, default 0, meaning 0 = registered-read mode and 1 = first-word-fall-through mode.
REQ-006 The block SHALL have port clk, input, 1 bit, meaning the single system clock; all state changes on its rising edge.
REQ-007 The block SHALL have port rst, input, 1 bit, meaning the asynchronous, active-low reset (0 = reset).
REQ-008 The block SHALL have port buf_in, input, DATA_W bits, meaning push data.
REQ-009 The block SHALL have port wr_en, input, 1 bit, meaning push request.
REQ-010 The block SHALL have port rd_en, input, 1 bit, meaning pop request.
REQ-011 The block SHALL have port flush, input, 1 bit, meaning synchronous empty-the-FIFO request.
REQ-012 The block SHALL have port buf_out, output, DATA_W bits, meaning pop data.
REQ-013 The block SHALL have ports buf_empty and buf_full, output, 1 bit each, meaning fill flags.
REQ-014 The block SHALL have ports almost_empty and almost_full, output, 1 bit each, meaning threshold flags.
REQ-015 The block SHALL have ports overflow and underflow, output, 1 bit each, meaning sticky error flags.
REQ-016 The block SHALL have port fifo_counter, output, ADDR_W+1 bits, meaning current occupancy, 0..DEPTH.

Function
REQ-017 A write SHALL be accepted iff wr_en=1 and buf_full=0; the accepted word is stored at wr_ptr, and wr_ptr increments modulo DEPTH.
REQ-018 A read SHALL be accepted iff rd_en=1 and buf_empty=0; rd_ptr increments modulo DEPTH.
REQ-019 fifo_counter SHALL behave as follows on an accepted write or read: +1 on write only, -1 on read only, unchanged on both or neither.
REQ-020 When full, simultaneous wr_en and rd_en SHALL accept the read and reject the write, giving count DEPTH-1 next cycle.
REQ-021 When empty, simultaneous wr_en and rd_en SHALL accept the write and reject the read, giving count 1 next cycle.
REQ-022 The threshold and fill flags SHALL be combinational from fifo_counter, as follows:
- buf_empty = (count==0)
- buf_full = (count==DEPTH)
- almost_full = (count>=AF_THRESH)
- almost_empty = (count<=AE_THRESH)
REQ-023 overflow SHALL set on wr_en while buf_full=1; underflow SHALL set on rd_en while buf_empty=1; both SHALL stay set until reset or flush.
REQ-024 With FWFT=0, buf_out SHALL load mem[rd_ptr] on the edge of an accepted read (one-cycle read latency) and SHALL hold otherwise.
REQ-025 With FWFT=1, buf_out SHALL combinationally present mem[rd_ptr] while buf_empty=0, and SHALL present all zeros while buf_empty=1; an accepted read advances to the next word in the following cycle.
REQ-026 A written word SHALL be poppable no earlier than the cycle after its write, i.e. no same-cycle write-to-read bypass.
REQ-027 flush=1 SHALL, at the next edge, override wr_en/rd_en that cycle, and SHALL:
- zero wr_ptr, rd_ptr, fifo_counter, overflow and underflow
- leave buf_out and memory contents unchanged
REQ-028 Pointer wrap from DEPTH-1 to 0 SHALL be seamless: data order is preserved across any number of wraps.

Reset
REQ-029 While rst=0, the block SHALL immediately, independent of clk, drive the following values:
- wr_ptr=0, rd_ptr=0, fifo_counter=0
- buf_out=0, overflow=0, underflow=0
- buf_empty=1, buf_full=0
- almost_empty=1, almost_full per thresholds
REQ-030 Memory SHALL NOT be reset; a reset mid-operation SHALL discard all stored words.
REQ-031 The first edge after rst releases SHALL obey normal write/read rules.

Verification (DATA_W=8, ADDR_W=3, AF_THRESH=6, AE_THRESH=1)
REQ-032 The bench SHALL cover this fill scenario: FWFT=0, push 0x01..0x08 -> buf_full=1, count=8, almost_full=1 from count 6; a 9th push -> overflow=1, count stays 8.
REQ-033 The bench SHALL cover this drain scenario: pop 8 words after the fill -> buf_out=0x01..0x08 in order, each one cycle after its rd_en; a 9th pop -> underflow=1, buf_out holds 0x08.
REQ-034 The bench SHALL cover this wrap scenario: 20 words are streamed, interleaving pushes and pops so that count stays between 2 and 5 -> all 20 words out in order, pointers wrap twice, and no error flags are set.
REQ-035 The bench SHALL cover these simultaneous-access scenarios:
- full with wr_en=rd_en=1 -> count 7, overflow=1
- empty with wr_en=rd_en=1 -> count 1, no underflow
REQ-036 The bench SHALL cover this FWFT scenario: FWFT=1, push 0xA5 -> buf_out=0xA5 the cycle after the push with no rd_en; pop -> buf_out=0x00 and buf_empty=1.
REQ-037 The bench SHALL cover these flush/reset scenarios:
- flush with 4 words and wr_en=1 -> count 0, flags cleared
- rst=0 asserted mid-clock-period -> outputs reach reset values before the next edge
